rom_rr_arbiter: RTL and testbench

//  - Shares one 8x4 lookup ROM between two requesters using round-robin arbitration.
//  - ROM contents are fixed: mem[i] = 2*i (4'b0000, 0010, 0100, ... 1110).
//  - Each lookup is a registered req/ack transaction; ack and rdata are valid together.
//  - Sits between two client FSMs and the ROM; the ROM is instantiated inside this block.

---
 rtl/rom_arb_pkg.sv | 15 +
 rtl/rom_table.sv | 24 ++
 rtl/rom_rr_arbiter.sv | 102 ++++++++++
 tb/tb_rom_rr_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// Shared definitions for the round-robin ROM arbiter slice.
//   ADDR_W / DATA_W : default ROM geometry (8 words of 4 bits)
//   state_t         : arbiter FSM state encoding
package rom_arb_pkg;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rom_table.sv
// Fixed combinational lookup ROM: word i holds the value 2*i.
// Ports:
//   addr in  AW bits  word index
//   data out DW bits  word contents
module rom_table #(
  parameter int AW = rom_arb_pkg::ADDR_W,
  parameter int DW = rom_arb_pkg::DATA_W
) (
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] data
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Contents are a pure function of the index, so the table folds to constants.
  always_comb begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = DW'(2 * i);
    end
  end

  assign data = mem[addr];

endmodule

// File: rtl/rom_rr_arbiter.sv
// Round-robin arbiter sharing one lookup ROM between two requesters.
// Each lookup takes three cycles (IDLE grant, READ, DONE with ack).
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   req0/addr0      requester 0 request (held until ack0) and address
//   req1/addr1      requester 1 request (held until ack1) and address
//   ack0/ack1       one-cycle pulse, rdata valid for that requester
//   rdata           registered ROM word, held until the next lookup
//   gnt_id          requester being served, or last served
//   busy            high while a lookup is in READ or DONE
module rom_rr_arbiter #(
  parameter int ADDR_W   = rom_arb_pkg::ADDR_W,
  parameter int DATA_W   = rom_arb_pkg::DATA_W,
  parameter int PRIO_RST = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              gnt_id,
  output logic              busy
);

  import rom_arb_pkg::*;

  state_t            state;
  logic              prio;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] rom_data;
  logic              pick;

  rom_table #(
    .AW (ADDR_W),
    .DW (DATA_W)
  ) u_rom (
    .addr (addr_q),
    .data (rom_data)
  );

  // A lone requester always wins; prio only breaks a tie.
  always_comb begin
    pick = 1'b0;
    if (req0 && req1) begin
      pick = prio;
    end else begin
      pick = req1;
    end
  end

  // Single FSM: every output is a flop, so nothing on req/addr reaches
  // the outputs combinationally. Reset drops any lookup in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      rdata  <= '0;
      gnt_id <= 1'(PRIO_RST);
      busy   <= 1'b0;
      prio   <= 1'(PRIO_RST);
      addr_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          ack0 <= 1'b0;
          ack1 <= 1'b0;
          if (req0 || req1) begin
            gnt_id <= pick;
            addr_q <= pick ? addr1 : addr0;
            busy   <= 1'b1;
            state  <= ST_READ;
          end
        end
        ST_READ: begin
          rdata <= rom_data;
          ack0  <= ~gnt_id;
          ack1  <= gnt_id;
          state <= ST_DONE;
        end
        ST_DONE: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          prio  <= ~gnt_id;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_rr_arbiter.sv
// Scoreboard bench for rom_rr_arbiter: requesters push the expected word
// (2*addr) per lookup, an independent monitor pops it on every ack and
// also enforces the round-robin rule (a requester waiting when the other
// is acked must be served next).
module tb_rom_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [2:0] addr0 = '0;
  logic [2:0] addr1 = '0;
  logic       ack0;
  logic       ack1;
  logic [3:0] rdata;
  logic       gnt_id;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int expQ0[$];
  int expQ1[$];
  int ackOrder[$];
  int ackCycle[$];
  int cycle = 0;
  bit monEn = 1'b0;
  bit mustValid = 1'b0;
  int mustId = 0;

  rom_rr_arbiter dut (
    .clk    (clk),
    .rst    (rst),
    .req0   (req0),
    .addr0  (addr0),
    .req1   (req1),
    .addr1  (addr1),
    .ack0   (ack0),
    .ack1   (ack1),
    .rdata  (rdata),
    .gnt_id (gnt_id),
    .busy   (busy)
  );

  // Free-running clock and a cycle stamp used for ack spacing.
  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Raise one request, wait for its ack, then drop it. lateAddr >= 0
  // rewrites the address right after the grant edge.
  task automatic applyStimulus(input int id, input int addr, input int lateAddr, output int lat);
    bit seen;
    @(posedge clk); #1;
    if (id == 0) begin
      req0 = 1'b1; addr0 = 3'(addr); expQ0.push_back(2 * addr);
    end else begin
      req1 = 1'b1; addr1 = 3'(addr); expQ1.push_back(2 * addr);
    end
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      lat++;
      if (lat == 1 && lateAddr >= 0) begin
        #1;
        if (id == 0) addr0 = 3'(lateAddr); else addr1 = 3'(lateAddr);
      end
      @(negedge clk);
      if ((id == 0 && ack0) || (id == 1 && ack1)) seen = 1'b1;
    end
    checkOutput(id == 0 ? "ack0_arrives" : "ack1_arrives", int'(seen), 1);
    @(posedge clk); #1;
    if (id == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    mustValid = 1'b0;
    expQ0.delete();
    expQ1.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Monitor: pop the scoreboard on every ack and track who must go next.
  always @(negedge clk) begin : monitor
    int id;
    if (monEn && !rst) begin
      if (mustValid && ((mustId == 0 && !req0) || (mustId == 1 && !req1))) mustValid = 1'b0;
      if (ack0 || ack1) begin
        id = ack1 ? 1 : 0;
        checkOutput("ack_onehot", int'(ack0 & ack1), 0);
        if (mustValid) checkOutput("rr_order", id, mustId);
        if (id == 0) begin
          if (expQ0.size() == 0) checkOutput("ack0_expected", expQ0.size(), 1);
          else checkOutput("rdata_req0", int'(rdata), expQ0.pop_front());
        end else begin
          if (expQ1.size() == 0) checkOutput("ack1_expected", expQ1.size(), 1);
          else checkOutput("rdata_req1", int'(rdata), expQ1.pop_front());
        end
        ackOrder.push_back(id);
        ackCycle.push_back(cycle);
        mustValid = (id == 0) ? req1 : req0;
        mustId = 1 - id;
      end
    end
  end

  // Hard time limit so the bench always reaches its summary.
  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Directed scenarios followed by a randomized two-client phase.
  initial begin
    int lat, lat0, lat1, base, expFirst, t2first;
    resetDut();
    @(negedge clk);
    checkOutput("rst_ack0", int'(ack0), 0);
    checkOutput("rst_ack1", int'(ack1), 0);
    checkOutput("rst_rdata", int'(rdata), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_gnt_id", int'(gnt_id), 0);
    monEn = 1'b1;

    $display("[TB] single request from requester 0");
    applyStimulus(0, 5, -1, lat);
    checkOutput("t1_latency", lat, 2);

    $display("[TB] simultaneous requests after reset");
    resetDut();
    base = ackOrder.size();
    fork
      applyStimulus(0, 3, -1, lat0);
      applyStimulus(1, 6, -1, lat1);
    join
    t2first = (ackOrder.size() > base) ? ackOrder[base] : -1;
    checkOutput("t2_first_id", t2first, 0);
    checkOutput("t2_lat0", lat0, 2);
    checkOutput("t2_lat1", lat1, 5);

    $display("[TB] both requests held continuously");
    base = ackOrder.size();
    expFirst = 1 - ackOrder[base - 1];
    @(posedge clk); #1;
    req0 = 1'b1; addr0 = 3'd1;
    req1 = 1'b1; addr1 = 3'd4;
    repeat (3) begin expQ0.push_back(2); expQ1.push_back(8); end
    for (int w = 0; w < 40; w++) begin
      @(posedge clk); #1;
      if (ackOrder.size() >= base + 6) break;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    checkOutput("t3_ack_count", ackOrder.size() - base, 6);
    for (int k = 0; k < 6 && base + k < ackOrder.size(); k++)
      checkOutput("t3_alt_id", ackOrder[base + k], (expFirst + k) % 2);
    for (int k = 1; k < 6 && base + k < ackCycle.size(); k++)
      checkOutput("t3_spacing", ackCycle[base + k] - ackCycle[base + k - 1], 3);

    $display("[TB] requester 1 alone, back to back");
    applyStimulus(1, 0, -1, lat); checkOutput("t4_lat_a", lat, 2);
    applyStimulus(1, 7, -1, lat); checkOutput("t4_lat_b", lat, 2);
    applyStimulus(1, 3, -1, lat); checkOutput("t4_lat_c", lat, 2);

    $display("[TB] reset during READ");
    @(posedge clk); #1;
    req0 = 1'b1; addr0 = 3'd6;
    @(posedge clk); #1;
    rst = 1'b1;
    req0 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("t5_ack0", int'(ack0), 0);
    checkOutput("t5_rdata", int'(rdata), 0);
    checkOutput("t5_busy", int'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mustValid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("t5_no_ack", int'(ack0 | ack1), 0);
    end
    applyStimulus(0, 5, -1, lat);
    checkOutput("t5_recover_lat", lat, 2);

    $display("[TB] address change after grant");
    applyStimulus(0, 2, 7, lat);
    checkOutput("t6_lat", lat, 2);

    $display("[TB] randomized two-client traffic");
    fork
      for (int k = 0; k < 25; k++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        applyStimulus(0, int'($urandom_range(0, 7)), -1, lat0);
      end
      for (int k = 0; k < 25; k++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        applyStimulus(1, int'($urandom_range(0, 7)), -1, lat1);
      end
    join

    repeat (4) @(posedge clk);
    checkOutput("drain_q0", expQ0.size(), 0);
    checkOutput("drain_q1", expQ1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
